// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the five-stage rv32i core.
//   Captures the decoded control word, PC, instruction, operands and
//   immediate from ID and presents them to EX one cycle later. Detects
//   load-use hazards against the instruction in EX, inserts a bubble when
//   one is found and counts those bubbles. WB writes that happen in the
//   same cycle are bypassed into the captured operands.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   id_valid/pc/instr/ctrl      ID instruction and its decoded control word
//   id_rs1_data/rs2_data/imm    ID register-file read data and immediate
//   wb_load_regfile/rd/data     same-cycle WB register write
//   mem_stall, flush            global freeze, squash of ID/EX
//   ex_*                        registered ID values presented to EX
//   stall_if_id                 combinational: hold PC and IF/ID this cycle
//   bubble_count                saturating count of load-use bubbles

package rv32i_pkg;
  typedef enum logic [6:0] {
    op_none  = 7'b0000000,
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    rv32i_opcode opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        load_regfile;
    logic        mem_read;
    logic        mem_write;
  } rv32i_control_word;
endpackage

module id_ex_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_instr,
  input  rv32i_control_word id_ctrl,
  input  logic [31:0]       id_rs1_data,
  input  logic [31:0]       id_rs2_data,
  input  logic [31:0]       id_imm,
  input  logic              wb_load_regfile,
  input  logic [4:0]        wb_rd,
  input  logic [31:0]       wb_data,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_instr,
  output rv32i_control_word ex_ctrl,
  output logic [31:0]       ex_rs1_data,
  output logic [31:0]       ex_rs2_data,
  output logic [31:0]       ex_imm,
  output logic              stall_if_id,
  output logic [PERF_W-1:0] bubble_count
);

  logic              valid_q, valid_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  rv32i_control_word ctrl_q, ctrl_d;
  logic [31:0]       rs1_q, rs1_d;
  logic [31:0]       rs2_q, rs2_d;
  logic [31:0]       imm_q, imm_d;
  logic [PERF_W-1:0] count_q, count_d;

  logic              use_rs1, use_rs2;
  logic [4:0]        rs1_idx, rs2_idx;
  logic              hazard;
  logic [31:0]       rs1_fwd, rs2_fwd;
  rv32i_control_word ctrl_cap;

  // Unused sources collapse to x0; since a hazard needs rd != 0, x0 never matches.
  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b1;
    case (id_ctrl.opcode)
      op_lui, op_auipc, op_jal: begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
      end
      op_jalr, op_load, op_imm: use_rs2 = 1'b0;
      default: ;
    endcase
    rs1_idx = use_rs1 ? id_instr[19:15] : 5'd0;
    rs2_idx = use_rs2 ? id_instr[24:20] : 5'd0;
  end

  assign hazard = valid_q && (ctrl_q.opcode == op_load) && ctrl_q.load_regfile &&
                  (ctrl_q.rd != 5'd0) && id_valid &&
                  ((ctrl_q.rd == rs1_idx) || (ctrl_q.rd == rs2_idx));

  assign stall_if_id = hazard && !flush;

  // WB bypass keys on the raw instruction fields, independent of opcode usage.
  always_comb begin
    rs1_fwd = id_rs1_data;
    rs2_fwd = id_rs2_data;
    if (wb_load_regfile && (wb_rd != 5'd0) && (wb_rd == id_instr[19:15])) rs1_fwd = wb_data;
    if (wb_load_regfile && (wb_rd != 5'd0) && (wb_rd == id_instr[24:20])) rs2_fwd = wb_data;
    ctrl_cap = id_ctrl;
    ctrl_cap.load_regfile = id_ctrl.load_regfile & id_valid;
  end

  // Priority: mem_stall holds everything, then flush, then hazard bubble, then capture.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ctrl_d  = ctrl_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    count_d = count_q;
    if (!mem_stall) begin
      if (flush || hazard) begin
        valid_d = 1'b0;
        pc_d    = '0;
        instr_d = '0;
        ctrl_d  = '0;
        rs1_d   = '0;
        rs2_d   = '0;
        imm_d   = '0;
        if (!flush && (count_q != '1)) count_d = count_q + 1'b1;
      end else begin
        valid_d = id_valid;
        pc_d    = id_pc;
        instr_d = id_instr;
        ctrl_d  = ctrl_cap;
        rs1_d   = rs1_fwd;
        rs2_d   = rs2_fwd;
        imm_d   = id_imm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      ctrl_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ctrl_q  <= ctrl_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      count_q <= count_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_instr     = instr_q;
  assign ex_ctrl      = ctrl_q;
  assign ex_rs1_data  = rs1_q;
  assign ex_rs2_data  = rs2_q;
  assign ex_imm       = imm_q;
  assign bubble_count = count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage (PERF_W=2): table of single-cycle vectors plus
// hand sequences for stall/flush interaction, async reset and saturation.
module tb_id_ex_stage;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_instr = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  rv32i_control_word id_ctrl = '0;
  logic wb_load_regfile = 1'b0;
  logic [4:0] wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic mem_stall = 1'b0, flush = 1'b0;
  logic ex_valid, stall_if_id;
  logic [31:0] ex_pc, ex_instr, ex_rs1_data, ex_rs2_data, ex_imm;
  rv32i_control_word ex_ctrl;
  logic [1:0] bubble_count;

  id_ex_stage #(.PERF_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_ctrl(id_ctrl), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .wb_load_regfile(wb_load_regfile), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_stall(mem_stall), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_instr(ex_instr), .ex_ctrl(ex_ctrl), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .stall_if_id(stall_if_id),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [31:0] pc, instr, rs1, rs2, imm; rv32i_control_word ctrl; logic [1:0] cnt;
  } exp_t;

  typedef struct {
    logic v; rv32i_opcode op; logic [4:0] rd, rs1, rs2; logic lr;
    logic [31:0] d1, d2; logic wlr; logic [4:0] wrd; logic [31:0] wd;
    logic stall; logic [31:0] e1, e2;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;
  exp_t sb[$];
  exp_t model;
  vec_t tbl[$];

  function automatic logic [31:0] cw(input rv32i_control_word c);
    logic [31:0] w;
    w = '0;
    w[$bits(rv32i_control_word)-1:0] = c;
    return w;
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic vec_t mkv(input int v, input rv32i_opcode op, input int rd, input int rs1,
                               input int rs2, input int lr, input logic [31:0] d1,
                               input logic [31:0] d2, input int wlr, input int wrd,
                               input logic [31:0] wd, input int stall,
                               input logic [31:0] e1, input logic [31:0] e2);
    vec_t r;
    r.v = 1'(v); r.op = op; r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.lr = 1'(lr);
    r.d1 = d1; r.d2 = d2; r.wlr = 1'(wlr); r.wrd = 5'(wrd); r.wd = wd;
    r.stall = 1'(stall); r.e1 = e1; r.e2 = e2;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_id(input logic v, input rv32i_opcode op, input int rd, input int rs1,
                        input int rs2, input logic lr, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] pc);
    rv32i_control_word c;
    c = '0;
    c.opcode = op;
    c.rd = 5'(rd);
    c.load_regfile = lr;
    c.mem_read = (op == op_load);
    c.mem_write = (op == op_store);
    id_valid = v;
    id_ctrl = c;
    id_instr = {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), op};
    id_rs1_data = d1;
    id_rs2_data = d2;
    id_pc = pc;
    id_imm = pc ^ 32'h0000_5A5A;
  endtask

  function automatic exp_t cap(input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    e.v = id_valid; e.pc = id_pc; e.instr = id_instr; e.imm = id_imm;
    e.ctrl = id_ctrl;
    if (!id_valid) e.ctrl.load_regfile = 1'b0;
    e.rs1 = r1; e.rs2 = r2; e.cnt = model.cnt;
    return e;
  endfunction

  function automatic exp_t bubble(input logic inc);
    exp_t e;
    e.v = 1'b0; e.pc = '0; e.instr = '0; e.imm = '0; e.ctrl = '0; e.rs1 = '0; e.rs2 = '0;
    e.cnt = inc ? sat_inc(model.cnt) : model.cnt;
    return e;
  endfunction

  // Advance one edge and compare EX against the oldest scoreboard entry.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty, got ex_valid=%b expected an entry", tag, ex_valid);
    end else begin
      e = sb.pop_front();
      chk({tag, ".ex_valid"}, {31'b0, ex_valid}, {31'b0, e.v});
      chk({tag, ".ex_pc"}, ex_pc, e.pc);
      chk({tag, ".ex_instr"}, ex_instr, e.instr);
      chk({tag, ".ex_ctrl"}, cw(ex_ctrl), cw(e.ctrl));
      chk({tag, ".ex_rs1"}, ex_rs1_data, e.rs1);
      chk({tag, ".ex_rs2"}, ex_rs2_data, e.rs2);
      chk({tag, ".ex_imm"}, ex_imm, e.imm);
      chk({tag, ".count"}, {30'b0, bubble_count}, {30'b0, e.cnt});
    end
    @(negedge clk);
  endtask

  task automatic expect_step(input string tag, input logic exp_stall, input exp_t e);
    #1;
    chk({tag, ".stall_if_id"}, {31'b0, stall_if_id}, {31'b0, exp_stall});
    model = e;
    sb.push_back(e);
    tick(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".ex_valid"}, {31'b0, ex_valid}, 32'd0);
    chk({tag, ".ex_pc"}, ex_pc, 32'd0);
    chk({tag, ".ex_instr"}, ex_instr, 32'd0);
    chk({tag, ".ex_ctrl"}, cw(ex_ctrl), 32'd0);
    chk({tag, ".ex_rs1"}, ex_rs1_data, 32'd0);
    chk({tag, ".ex_rs2"}, ex_rs2_data, 32'd0);
    chk({tag, ".ex_imm"}, ex_imm, 32'd0);
    chk({tag, ".count"}, {30'b0, bubble_count}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sat_exp [5];
    vec_t r;
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    //          v  op        rd rs1 rs2 lr  d1          d2          wlr wrd wd            st e1            e2
    tbl.push_back(mkv(1, op_load,  5, 2, 0, 1, 32'h10,      32'h20,      0, 0, 32'h0,        0, 32'h10,       32'h20));
    tbl.push_back(mkv(1, op_reg,   6, 5, 7, 1, 32'hA,       32'hB,       0, 0, 32'h0,        1, 32'h0,        32'h0));
    tbl.push_back(mkv(1, op_reg,   6, 5, 7, 1, 32'hA,       32'hB,       0, 0, 32'h0,        0, 32'hA,        32'hB));
    tbl.push_back(mkv(1, op_load,  5, 1, 0, 1, 32'h30,      32'h40,      0, 0, 32'h0,        0, 32'h30,       32'h40));
    tbl.push_back(mkv(1, op_lui,   5, 5, 5, 1, 32'h1,       32'h2,       0, 0, 32'h0,        0, 32'h1,        32'h2));
    tbl.push_back(mkv(1, op_load,  0, 1, 0, 1, 32'h3,       32'h4,       0, 0, 32'h0,        0, 32'h3,        32'h4));
    tbl.push_back(mkv(1, op_reg,   1, 0, 0, 1, 32'h5,       32'h6,       0, 0, 32'h0,        0, 32'h5,        32'h6));
    tbl.push_back(mkv(1, op_load,  5, 1, 0, 1, 32'h7,       32'h8,       0, 0, 32'h0,        0, 32'h7,        32'h8));
    tbl.push_back(mkv(1, op_imm,   1, 2, 5, 1, 32'h9,       32'hC,       0, 0, 32'h0,        0, 32'h9,        32'hC));
    tbl.push_back(mkv(1, op_reg,   4, 3, 9, 1, 32'h1111,    32'h2222,    1, 3, 32'hDEADBEEF, 0, 32'hDEADBEEF, 32'h2222));
    tbl.push_back(mkv(1, op_reg,   4, 3, 9, 1, 32'h1111,    32'h2222,    1, 0, 32'hDEADBEEF, 0, 32'h1111,     32'h2222));
    tbl.push_back(mkv(1, op_reg,   4, 3, 9, 1, 32'h1111,    32'h2222,    1, 9, 32'hCAFEF00D, 0, 32'h1111,     32'hCAFEF00D));
    tbl.push_back(mkv(1, op_reg,   4, 3, 9, 1, 32'h1111,    32'h2222,    0, 3, 32'hDEADBEEF, 0, 32'h1111,     32'h2222));
    tbl.push_back(mkv(1, op_lui,   4, 3, 0, 1, 32'h1111,    32'h2222,    1, 3, 32'h55,       0, 32'h55,       32'h2222));
    tbl.push_back(mkv(0, op_load,  5, 1, 0, 1, 32'hE,       32'hF,       0, 0, 32'h0,        0, 32'hE,        32'hF));
    tbl.push_back(mkv(1, op_reg,   6, 5, 5, 1, 32'h11,      32'h12,      0, 0, 32'h0,        0, 32'h11,       32'h12));
    tbl.push_back(mkv(1, op_load,  5, 1, 0, 1, 32'h13,      32'h14,      0, 0, 32'h0,        0, 32'h13,       32'h14));
    tbl.push_back(mkv(1, op_store, 0, 2, 5, 0, 32'h15,      32'h16,      0, 0, 32'h0,        1, 32'h0,        32'h0));
    tbl.push_back(mkv(1, op_store, 0, 2, 5, 0, 32'h15,      32'h16,      0, 0, 32'h0,        0, 32'h15,       32'h16));
    tbl.push_back(mkv(1, op_load,  5, 1, 0, 0, 32'h17,      32'h18,      0, 0, 32'h0,        0, 32'h17,       32'h18));
    tbl.push_back(mkv(1, op_reg,   6, 5, 0, 1, 32'h19,      32'h1A,      0, 0, 32'h0,        0, 32'h19,       32'h1A));

    model = bubble(1'b0);
    model.cnt = 2'd0;
    #2;
    check_zero("reset_initial");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      r = tbl[i];
      set_id(r.v, r.op, r.rd, r.rs1, r.rs2, r.lr, r.d1, r.d2, 32'h100 + 32'(i) * 4);
      wb_load_regfile = r.wlr;
      wb_rd = r.wrd;
      wb_data = r.wd;
      if (r.stall) expect_step($sformatf("vec%0d", i), 1'b1, bubble(1'b1));
      else expect_step($sformatf("vec%0d", i), 1'b0, cap(r.e1, r.e2));
    end
    wb_load_regfile = 1'b0;

    // flush together with a hazard: flush wins, no count
    set_id(1, op_load, 5, 1, 0, 1, 32'h21, 32'h22, 32'h400);
    expect_step("ff_lw", 1'b0, cap(32'h21, 32'h22));
    set_id(1, op_reg, 6, 5, 7, 1, 32'h23, 32'h24, 32'h404);
    flush = 1'b1;
    expect_step("flush_hz", 1'b0, bubble(1'b0));
    flush = 1'b0;

    // mem_stall with flush: hold for 3 cycles, then flush takes effect
    set_id(1, op_load, 5, 1, 0, 1, 32'h31, 32'h32, 32'h500);
    expect_step("ms_lw", 1'b0, cap(32'h31, 32'h32));
    set_id(1, op_reg, 6, 5, 7, 1, 32'h33, 32'h34, 32'h504);
    mem_stall = 1'b1;
    flush = 1'b1;
    for (int k = 0; k < 3; k++) expect_step($sformatf("ms_flush_hold%0d", k), 1'b0, model);
    mem_stall = 1'b0;
    expect_step("ms_flush_drop", 1'b0, bubble(1'b0));
    flush = 1'b0;

    // mem_stall with a hazard: stall_if_id stays up, bubble on first free edge
    set_id(1, op_load, 5, 1, 0, 1, 32'h41, 32'h42, 32'h600);
    expect_step("mh_lw", 1'b0, cap(32'h41, 32'h42));
    set_id(1, op_reg, 6, 7, 5, 1, 32'h43, 32'h44, 32'h604);
    mem_stall = 1'b1;
    for (int k = 0; k < 2; k++) expect_step($sformatf("ms_hz_hold%0d", k), 1'b1, model);
    mem_stall = 1'b0;
    expect_step("ms_hz_bubble", 1'b1, bubble(1'b1));
    expect_step("ms_hz_capture", 1'b0, cap(32'h43, 32'h44));

    // counter already at max: bubble still inserted, count holds
    set_id(1, op_load, 5, 1, 0, 1, 32'h51, 32'h52, 32'h700);
    expect_step("max_lw", 1'b0, cap(32'h51, 32'h52));
    set_id(1, op_reg, 6, 5, 7, 1, 32'h53, 32'h54, 32'h704);
    expect_step("max_bubble", 1'b1, bubble(1'b1));

    // asynchronous reset mid-cycle
    @(posedge clk);
    #1;
    chk("pre_reset.ex_valid", {31'b0, ex_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model = bubble(1'b0);
    model.cnt = 2'd0;
    @(negedge clk);
    @(negedge clk);
    check_zero("reset_held");
    rst_n = 1'b1;

    // saturation sequence 1,2,3,3,3
    for (int k = 0; k < 5; k++) begin
      set_id(1, op_load, 5, 1, 0, 1, 32'h61, 32'h62, 32'h800 + 32'(k) * 8);
      expect_step($sformatf("sat_lw%0d", k), 1'b0, cap(32'h61, 32'h62));
      set_id(1, op_reg, 6, 5, 7, 1, 32'h63, 32'h64, 32'h804 + 32'(k) * 8);
      expect_step($sformatf("sat_bub%0d", k), 1'b1, bubble(1'b1));
      chk($sformatf("sat_seq%0d", k), {30'b0, bubble_count}, {30'b0, sat_exp[k]});
    end

    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between Decode and Execute for the five-stage rv32i core, with integrated load-use hazard detection and bubble insertion. It captures the decoded control word, PC, instruction, register-file operands and immediate from ID, and presents them to EX and the EX forwarding-select logic one cycle later. It honours the global memory stall and branch flush, and bypasses same-cycle WB register writes into the captured operands. A saturating counter records inserted bubbles for performance analysis.

## Interface
- PERF_W, 16, width of the bubble counter.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  32  PC of the ID instruction.
- id_instr  in  32  raw instruction word.
- id_ctrl  in  rv32i_control_word  decoded control word (opcode, rd, load_regfile, ...).
- id_rs1_data, id_rs2_data  in  32 each  register-file read data.
- id_imm  in  32  decoded immediate.
- wb_load_regfile  in  1  WB writes the register file this cycle.
- wb_rd  in  5  WB destination register.
- wb_data  in  32  WB write data.
- mem_stall  in  1  global freeze (imem/dmem not ready).
- flush  in  1  squash ID/EX (taken branch/jump resolved in EX).
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_instr, ex_rs1_data, ex_rs2_data, ex_imm  out  32 each  registered ID values.
- ex_ctrl  out  rv32i_control_word  registered control word.
- stall_if_id  out  1  combinational; hold PC and IF/ID this cycle.
- bubble_count  out  PERF_W  saturating count of load-use bubbles.

## Operation
- Source-register usage by id_ctrl.opcode:
  - op_lui, op_auipc, op_jal: none.
  - op_jalr, op_load, op_imm: rs1 = id_instr[19:15] only.
  - All others: rs1 = id_instr[19:15], rs2 = id_instr[24:20].
  - An unused source is treated as x0 and never matches.
- Load-use hazard: ex_valid && ex_ctrl.opcode == op_load && ex_ctrl.load_regfile && ex_ctrl.rd != 0 && id_valid && ex_ctrl.rd equals a used rs.
  - stall_if_id = hazard && !flush.
  - stall_if_id remains asserted during mem_stall if the hazard is present.
- Register update priority, highest first:
  1. Reset: all outputs 0, ctrl all-zero.
  2. mem_stall: hold every register. flush is ignored; its source holds it until the stall drops.
  3. flush: load a bubble.
  4. Hazard: load a bubble and increment bubble_count.
  5. Otherwise: capture ID.
- Bubble: ex_valid=0, ex_ctrl all-zero (so load_regfile=0), and pc/instr/data/imm all 0.
- Capture path:
  - ex_valid takes id_valid.
  - If id_valid=0, the captured ctrl.load_regfile is forced to 0.
  - WB bypass: if wb_load_regfile && wb_rd != 0 && wb_rd == id_instr[19:15], ex_rs1_data takes wb_data; the same rule applies to rs2 with id_instr[24:20].
  - Bypass is applied regardless of opcode usage.
- bubble_count increments by 1 per hazard bubble actually loaded (not while mem_stall). It saturates at 2^PERF_W-1 and is cleared only by reset.

## Timing
- Latency: ID values appear on ex_* one cycle after a non-stalled capture edge.
- stall_if_id is purely combinational from ex_* and id_*, with no registered delay.
  - A load in EX followed by a dependent instruction in ID yields exactly one bubble cycle, because the next cycle ex_valid=0 clears the hazard.
  - The dependent instruction is then captured. EX forwarding supplies the loaded value from MEM/WB.
- Reset is asynchronous: asserting rst_n low mid-operation zeroes outputs immediately, regardless of clk. Deassertion is effective from the next rising edge.
- Simultaneous flush and hazard: flush wins, stall_if_id=0, and the counter does not increment.
- Simultaneous mem_stall and hazard: registers hold and stall_if_id=1. The bubble is inserted on the first non-stalled edge.
- Counter at max: the hazard still inserts a bubble, and the count stays at max.

## Test plan
- Reset: drive rst_n=0 mid-stream with clk toggling → all ex_* = 0, ex_valid=0, bubble_count=0, asynchronously.
- Load-use: EX holds lw x5 (rd=5, load_regfile=1) and ID holds add x6,x5,x7 → stall_if_id=1 for one cycle, one bubble, bubble_count=1. On the next edge the add is captured with ex_valid=1.
- No false hazard:
  - EX holds lw x5 and ID holds lui x5 → stall_if_id=0.
  - EX holds lw x0 and ID holds add x1,x0,x0 → stall_if_id=0.
  - ID addi x1,x2,5 with instr[24:20]=5 vs EX lw x5 → stall_if_id=0 (rs2 unused).
- WB bypass: id_rs1_data=0x1111, wb_load_regfile=1, wb_rd=rs1=3, wb_data=0xDEADBEEF → ex_rs1_data=0xDEADBEEF. With wb_rd=0 → 0x1111.
- Stall/flush:
  - mem_stall=1 for 3 cycles with flush=1 → outputs unchanged.
  - Drop mem_stall with flush still 1 → bubble (ex_valid=0, ctrl zero).
- Saturation: PERF_W=2 with 5 hazard bubbles → bubble_count sequence 1,2,3,3,3.
